// File: rtl/port_input_sync_pkg.sv
// Shared constants and helpers for the port input conditioning block.
// Latency: n/a (package only).
// Backpressure: n/a.
package port_input_sync_pkg;

    localparam logic [7:0] PORT_RV    = 8'hFF; // pin/port value while in reset
    localparam int         INT0_BIT   = 2;     // P3.2
    localparam int         INT1_BIT   = 3;     // P3.3
    localparam int         FILT_CNT_W = 4;     // holds FILT_LEN up to 15

    // TCON.ITx encoding
    typedef enum logic {
        IE_LEVEL = 1'b0,
        IE_EDGE  = 1'b1
    } ie_mode_t;

    // Next value of an IEx request flag.
    // Priority within one cycle: hardware set > software write > ack clear.
    // Level mode ignores ack and only lets a software write live for one cycle.
    function automatic logic ie_next(
        input ie_mode_t mode,
        input logic     cur,
        input logic     fall,
        input logic     level,
        input logic     wr,
        input logic     wdat,
        input logic     ack
    );
        logic nxt;
        nxt = cur;
        if (mode == IE_EDGE) begin
            if (fall)     nxt = 1'b1;
            else if (wr)  nxt = wdat;
            else if (ack) nxt = 1'b0;
        end else begin
            if (!level)   nxt = 1'b1;
            else if (wr)  nxt = wdat;
            else          nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/port_glitch_filter.sv
// Synchronizer + glitch filter + falling-edge pulse for one external interrupt pin.
// Latency: pad to level = SYNC_STAGES + FILT_LEN clk; fall pulse one clk after level drops.
// Backpressure: none, free-running.
//  clk   in  global clock
//  rst   in  async active-low reset
//  pad   in  raw asynchronous pin
//  level out filtered level (resets to 1)
//  fall  out registered one-cycle pulse on a filtered 1->0 transition
module port_glitch_filter
    import port_input_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam logic [FILT_CNT_W-1:0] FILT_LEN_C = FILT_CNT_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_CNT_W-1:0]  cnt;
    logic [FILT_CNT_W-1:0]  cnt_inc;
    logic                   smp;
    logic                   lvl_d;

    assign smp     = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            cnt    <= '0;
            level  <= 1'b1;
            lvl_d  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            lvl_d  <= level;
            // registering the pulse puts the ie flag two clk after the level change
            fall   <= lvl_d & ~level;
            // any sample agreeing with the current level restarts the run count,
            // so runs shorter than FILT_LEN never reach the output
            if (smp == level) begin
                cnt <= '0;
            end else if (cnt_inc == FILT_LEN_C) begin
                level <= smp;
                cnt   <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/port_input_sync.sv
// Conditions the 32 raw port pins for PORTS: per-bit synchronizer, INT0/INT1 glitch filters, IE0/IE1 flags.
// Latency: pins SYNC_STAGES clk; P3.2/P3.3 SYNC_STAGES+FILT_LEN clk; pad to ie (edge mode) SYNC_STAGES+FILT_LEN+2 clk.
// Backpressure: none, free-running.
//  clk, rst            global clock, async active-low reset
//  pad0i..pad3i        raw pins (pad3i[2]=INT0, pad3i[3]=INT1)
//  port0i..port3i      synchronized pins to PORTS (port3i[3:2] filtered)
//  it0, it1            1 = falling-edge mode, 0 = low-level mode
//  int0ack, int1ack    interrupt controller vector acknowledge pulses
//  iewe, iedatai       software write of {IE1,IE0}
//  ie0, ie1            interrupt request flags
module port_input_sync
    import port_input_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pad0i,
    input  logic [7:0] pad1i,
    input  logic [7:0] pad2i,
    input  logic [7:0] pad3i,
    output logic [7:0] port0i,
    output logic [7:0] port1i,
    output logic [7:0] port2i,
    output logic [7:0] port3i,
    input  logic       it0,
    input  logic       it1,
    input  logic       int0ack,
    input  logic       int1ack,
    input  logic       iewe,
    input  logic [1:0] iedatai,
    output logic       ie0,
    output logic       ie1
);

    localparam int INT0_IDX = 24 + INT0_BIT;
    localparam int INT1_IDX = 24 + INT1_BIT;

    logic [31:0] pad_all;
    logic [31:0] port_all;
    logic        fall0;
    logic        fall1;

    assign pad_all = {pad3i, pad2i, pad1i, pad0i};

    // Plain synchronizers for every pin except the two interrupt inputs,
    // which get their own chain inside the glitch filters.
    for (genvar i = 0; i < 32; i++) begin : g_bit
        if (i != INT0_IDX && i != INT1_IDX) begin : g_sync
            logic [SYNC_STAGES-1:0] q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) q <= {SYNC_STAGES{PORT_RV[i%8]}};
                else      q <= {q[SYNC_STAGES-2:0], pad_all[i]};
            end
            assign port_all[i] = q[SYNC_STAGES-1];
        end
    end

    port_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_int0_filt (
        .clk   (clk),
        .rst   (rst),
        .pad   (pad_all[INT0_IDX]),
        .level (port_all[INT0_IDX]),
        .fall  (fall0)
    );

    port_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_int1_filt (
        .clk   (clk),
        .rst   (rst),
        .pad   (pad_all[INT1_IDX]),
        .level (port_all[INT1_IDX]),
        .fall  (fall1)
    );

    assign port0i = port_all[7:0];
    assign port1i = port_all[15:8];
    assign port2i = port_all[23:16];
    assign port3i = port_all[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie0 <= 1'b0;
            ie1 <= 1'b0;
        end else begin
            ie0 <= ie_next(ie_mode_t'(it0), ie0, fall0, port_all[INT0_IDX],
                           iewe, iedatai[0], int0ack);
            ie1 <= ie_next(ie_mode_t'(it1), ie1, fall1, port_all[INT1_IDX],
                           iewe, iedatai[1], int1ack);
        end
    end

endmodule

// File: tb/tb_port_input_sync.sv
// Directed bench for port_input_sync: vector table for pin synchronization plus
// hand sequences for reset, glitch filtering, ack, level mode and software writes.
module tb_port_input_sync;

    logic       clk;
    logic       rst;
    logic [7:0] pad0i, pad1i, pad2i, pad3i;
    logic [7:0] port0i, port1i, port2i, port3i;
    logic       it0, it1, int0ack, int1ack, iewe;
    logic [1:0] iedatai;
    logic       ie0, ie1;

    int n_vec = 0;
    int n_bad = 0;

    port_input_sync dut (
        .clk     (clk),
        .rst     (rst),
        .pad0i   (pad0i),
        .pad1i   (pad1i),
        .pad2i   (pad2i),
        .pad3i   (pad3i),
        .port0i  (port0i),
        .port1i  (port1i),
        .port2i  (port2i),
        .port3i  (port3i),
        .it0     (it0),
        .it1     (it1),
        .int0ack (int0ack),
        .int1ack (int1ack),
        .iewe    (iewe),
        .iedatai (iedatai),
        .ie0     (ie0),
        .ie1     (ie1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p0, p1, p2, p3;
        logic [7:0] e0, e1, e2, e3;
    } vec_t;

    vec_t tbl [5];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ports();
        return {port3i, port2i, port1i, port0i};
    endfunction

    function automatic logic [31:0] ies();
        return {30'd0, ie1, ie0};
    endfunction

    task automatic reset_idle(input logic m0, input logic m1);
        rst = 1'b0;
        {pad3i, pad2i, pad1i, pad0i} = 32'hFFFF_FFFF;
        it0 = m0; it1 = m1;
        int0ack = 1'b0; int1ack = 1'b0; iewe = 1'b0; iedatai = 2'b00;
        tick(1);
        rst = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [31:0] prev;

        // ---------------- reset and release ----------------
        rst = 1'b0;
        {pad3i, pad2i, pad1i, pad0i} = 32'h0;
        it0 = 1'b1; it1 = 1'b1;
        int0ack = 1'b0; int1ack = 1'b0; iewe = 1'b0; iedatai = 2'b00;
        tick(2);
        chk("reset_ports", ports(), 32'hFFFF_FFFF);
        chk("reset_ie", ies(), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("release_plus1", ports(), 32'hFFFF_FFFF);
        tick(1);
        chk("release_plus2", ports(), 32'h0C00_0000);
        tick(2);
        chk("release_plus4", ports(), 32'h0C00_0000);
        tick(1);
        chk("release_plus5", ports(), 32'h0000_0000);

        // ---------------- table-driven sync latency ----------------
        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0C};
        tbl[1] = '{8'h00, 8'hA5, 8'h00, 8'h0C, 8'h00, 8'hA5, 8'h00, 8'h0C};
        tbl[2] = '{8'h5A, 8'hFF, 8'h3C, 8'hFF, 8'h5A, 8'hFF, 8'h3C, 8'hFF};
        tbl[3] = '{8'h81, 8'h7E, 8'hC3, 8'h9D, 8'h81, 8'h7E, 8'hC3, 8'h9D};
        // INT pins drop: filtered bits still high two clk later
        tbl[4] = '{8'hFF, 8'h00, 8'hAA, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h0C};

        {pad3i, pad2i, pad1i, pad0i} = 32'hFFFF_FFFF;
        tick(8);
        prev = 32'hFFFF_FFFF;
        for (int v = 0; v < 5; v++) begin
            pad0i = tbl[v].p0; pad1i = tbl[v].p1; pad2i = tbl[v].p2; pad3i = tbl[v].p3;
            tick(1);
            chk($sformatf("vec%0d_plus1", v), ports(), prev);
            tick(1);
            prev = {tbl[v].e3, tbl[v].e2, tbl[v].e1, tbl[v].e0};
            chk($sformatf("vec%0d_plus2", v), ports(), prev);
        end
        tick(2);
        chk("int_pins_plus4", 32'(port3i), 32'h0C);
        tick(1);
        chk("int_pins_plus5", 32'(port3i), 32'h00);

        // ---------------- glitch filter, edge mode ----------------
        reset_idle(1'b1, 1'b1);
        chk("idle_ie", ies(), 32'h0);
        pad3i[2] = 1'b0;
        tick(2);
        pad3i[2] = 1'b1;
        tick(10);
        chk("glitch2_ie0", 32'(ie0), 32'h0);
        chk("glitch2_level", 32'(port3i[2]), 32'h1);
        pad3i[2] = 1'b0;
        tick(3);
        pad3i[2] = 1'b1;
        tick(2);
        chk("pulse3_level_plus5", 32'(port3i[2]), 32'h0);
        tick(1);
        chk("pulse3_ie0_plus6", 32'(ie0), 32'h0);
        tick(1);
        chk("pulse3_ie0_plus7", 32'(ie0), 32'h1);

        // ---------------- ack ----------------
        int0ack = 1'b1;
        tick(1);
        int0ack = 1'b0;
        chk("ack_clears_ie0", 32'(ie0), 32'h0);
        tick(4);
        pad3i[2] = 1'b0;
        tick(6);
        chk("fall_ack_before", 32'(ie0), 32'h0);
        int0ack = 1'b1;
        tick(1);
        int0ack = 1'b0;
        chk("fall_beats_ack", 32'(ie0), 32'h1);
        pad3i[2] = 1'b1;
        tick(8);

        // ---------------- level mode on INT1 ----------------
        reset_idle(1'b1, 1'b0);
        chk("lvl_idle_ie1", 32'(ie1), 32'h0);
        pad3i[3] = 1'b0;
        tick(5);
        chk("lvl_low_plus5", 32'(ie1), 32'h0);
        tick(1);
        chk("lvl_low_plus6", 32'(ie1), 32'h1);
        int1ack = 1'b1;
        tick(1);
        int1ack = 1'b0;
        chk("lvl_ack_ignored", 32'(ie1), 32'h1);
        iewe = 1'b1; iedatai = 2'b00;
        tick(1);
        iewe = 1'b0;
        chk("lvl_hw_beats_sw", 32'(ie1), 32'h1);
        tick(2);
        pad3i[3] = 1'b1;
        tick(5);
        chk("lvl_high_plus5", 32'(ie1), 32'h1);
        tick(1);
        chk("lvl_high_plus6", 32'(ie1), 32'h0);
        iewe = 1'b1; iedatai = 2'b10;
        tick(1);
        iewe = 1'b0;
        chk("lvl_sw_one_cycle", 32'(ie1), 32'h1);
        tick(1);
        chk("lvl_sw_expires", 32'(ie1), 32'h0);
        // edge -> level switch while flag set
        it1 = 1'b1;
        iewe = 1'b1; iedatai = 2'b10;
        tick(1);
        iewe = 1'b0;
        chk("edge_sw_set", 32'(ie1), 32'h1);
        tick(1);
        chk("edge_sw_holds", 32'(ie1), 32'h1);
        it1 = 1'b0;
        tick(1);
        chk("mode_switch_follows_level", 32'(ie1), 32'h0);

        // ---------------- software writes and async reset ----------------
        reset_idle(1'b1, 1'b1);
        iewe = 1'b1; iedatai = 2'b11;
        tick(1);
        iewe = 1'b0;
        chk("sw_write_11", ies(), 32'h3);
        tick(1);
        chk("sw_hold_11", ies(), 32'h3);
        iewe = 1'b1; iedatai = 2'b00;
        tick(1);
        iewe = 1'b0;
        chk("sw_write_00", ies(), 32'h0);
        iewe = 1'b1; iedatai = 2'b11; int0ack = 1'b1;
        tick(1);
        iewe = 1'b0; int0ack = 1'b0;
        chk("sw_beats_ack", ies(), 32'h3);
        iewe = 1'b1; iedatai = 2'b10;
        tick(1);
        iewe = 1'b0;
        chk("sw_write_10", ies(), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ie", ies(), 32'h0);
        chk("async_rst_ports", ports(), 32'hFFFF_FFFF);
        tick(1);
        rst = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
